// File: rtl/sig_conflict_monitor.sv
// Purpose: independent lamp monitor for a two-head traffic-light controller; trips to FLASH on the first violation.
// Latency: lamp pins -> CUR/PRV (1 edge) -> FAULT/FCODE/FLASH (1 more edge), i.e. 2 edges pin-to-fault.
// Backpressure: none; passive observer of lamp drives, ACK is a level sampled every cycle.
//
// Ports:
//   CK                  clock, rising edge
//   CLR                 synchronous active-low reset
//   GRN1/YLW1/RED1      head-1 lamp drives
//   GRN2/YLW2/RED2      head-2 lamp drives
//   TEST                accelerated-test mode, suppresses the stuck-output check
//   ACK                 fault acknowledge (honoured only in TRIP with both heads red)
//   FAULT, FCODE[2:0]   latched fault flag and first fault code (0 none .. 5 STUCK)
//   FLASH               force-flash request, high while tripped
//   ARMED               high while actively checking (RUN)
module sig_conflict_monitor #(
  parameter int MIN_YLW = 3,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       TEST,
  input  logic       ACK,
  output logic       FAULT,
  output logic [2:0] FCODE,
  output logic       FLASH,
  output logic       ARMED
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRIP = 2'd2
  } state_e;

  // Head codes are {G,Y,R}; only these three one-hot patterns are valid.
  localparam logic [2:0] H_G = 3'b100;
  localparam logic [2:0] H_Y = 3'b010;
  localparam logic [2:0] H_R = 3'b001;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_LAMP      = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_SEQ       = 3'd3;
  localparam logic [2:0] FC_SHORT_YLW = 3'd4;
  localparam logic [2:0] FC_STUCK     = 3'd5;

  localparam logic [CNT_W-1:0] MIN_YLW_C = CNT_W'(MIN_YLW);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       fcode_q, fcode_d;
  logic [2:0]       cur1_q, cur2_q, prv1_q, prv2_q;
  logic [CNT_W-1:0] ylw1_q, ylw1_d, ylw2_q, ylw2_d;
  logic [CNT_W-1:0] idle_q, idle_d;

  logic       v1, v2;
  logic       chk_lamp, chk_conflict, chk_seq, chk_short, chk_stuck;
  logic       clr_cnt;
  logic [2:0] viol_code;

  function automatic logic head_valid(input logic [2:0] h);
    return (h == H_G) || (h == H_Y) || (h == H_R);
  endfunction

  function automatic logic seq_legal(input logic [2:0] p, input logic [2:0] c);
    logic ok;
    ok = 1'b0;
    case (p)
      H_G:     ok = (c == H_G) || (c == H_Y);
      H_Y:     ok = (c == H_Y) || (c == H_R);
      H_R:     ok = (c == H_R) || (c == H_G);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + ONE_C;
  endfunction

  // Violation checks on the registered samples.
  always_comb begin
    v1           = head_valid(cur1_q);
    v2           = head_valid(cur2_q);
    chk_lamp     = !v1 || !v2;
    chk_conflict = ((cur1_q == H_G) || (cur1_q == H_Y)) &&
                   ((cur2_q == H_G) || (cur2_q == H_Y));
    chk_seq      = !seq_legal(prv1_q, cur1_q) || !seq_legal(prv2_q, cur2_q);
    // Yellow counters trail CUR by one edge, so while PRV is yellow they hold
    // the full yellow dwell that is ending now.
    chk_short    = ((prv1_q == H_Y) && (cur1_q != H_Y) && (ylw1_q < MIN_YLW_C)) ||
                   ((prv2_q == H_Y) && (cur2_q != H_Y) && (ylw2_q < MIN_YLW_C));
    chk_stuck    = !TEST && (idle_q >= TIMEOUT_C);

    viol_code = FC_NONE;
    if (chk_lamp)          viol_code = FC_LAMP;
    else if (chk_conflict) viol_code = FC_CONFLICT;
    else if (chk_seq)      viol_code = FC_SEQ;
    else if (chk_short)    viol_code = FC_SHORT_YLW;
    else if (chk_stuck)    viol_code = FC_STUCK;
  end

  // State machine: next state and latched fault code.
  always_comb begin
    state_d = state_q;
    fcode_d = fcode_q;
    clr_cnt = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (v1 && v2 && ((cur1_q == H_R) || (cur2_q == H_R))) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (viol_code != FC_NONE) begin
          state_d = ST_TRIP;
          fcode_d = viol_code;
        end
      end
      ST_TRIP: begin
        // Only a safe all-red picture releases the trip; first code is held.
        if (ACK && (cur1_q == H_R) && (cur2_q == H_R)) begin
          state_d = ST_INIT;
          fcode_d = FC_NONE;
          clr_cnt = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        fcode_d = FC_NONE;
      end
    endcase
  end

  // Dwell and idle counters.
  always_comb begin
    ylw1_d = (clr_cnt || (cur1_q != H_Y)) ? '0 : sat_inc(ylw1_q);
    ylw2_d = (clr_cnt || (cur2_q != H_Y)) ? '0 : sat_inc(ylw2_q);
    if (clr_cnt || (state_q != ST_RUN) || TEST ||
        (cur1_q != prv1_q) || (cur2_q != prv2_q)) begin
      idle_d = '0;
    end else begin
      idle_d = sat_inc(idle_q);
    end
  end

  always_ff @(posedge CK) begin
    if (!CLR) begin
      state_q <= ST_INIT;
      fcode_q <= FC_NONE;
      cur1_q  <= '0;
      cur2_q  <= '0;
      prv1_q  <= '0;
      prv2_q  <= '0;
      ylw1_q  <= '0;
      ylw2_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      fcode_q <= fcode_d;
      cur1_q  <= {GRN1, YLW1, RED1};
      cur2_q  <= {GRN2, YLW2, RED2};
      prv1_q  <= cur1_q;
      prv2_q  <= cur2_q;
      ylw1_q  <= ylw1_d;
      ylw2_q  <= ylw2_d;
      idle_q  <= idle_d;
    end
  end

  assign FAULT = (state_q == ST_TRIP);
  assign FLASH = (state_q == ST_TRIP);
  assign ARMED = (state_q == ST_RUN);
  assign FCODE = fcode_q;

endmodule

// File: tb/tb_sig_conflict_monitor.sv
module tb_sig_conflict_monitor;

  localparam logic [2:0] G  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] R  = 3'b001;
  localparam logic [2:0] GY = 3'b110;

  logic       CK, CLR;
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
  logic       TEST, ACK;
  logic       FAULT, FLASH, ARMED;
  logic [2:0] FCODE;

  int n_cmp = 0;
  int n_bad = 0;

  sig_conflict_monitor #(.MIN_YLW(3), .TIMEOUT(64), .CNT_W(8)) dut (
    .CK(CK), .CLR(CLR),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .TEST(TEST), .ACK(ACK),
    .FAULT(FAULT), .FCODE(FCODE), .FLASH(FLASH), .ARMED(ARMED)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Advance n rising edges; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic set_lamps(input logic [2:0] h1, input logic [2:0] h2);
    {GRN1, YLW1, RED1} = h1;
    {GRN2, YLW2, RED2} = h2;
  endtask

  // Clear a trip: all-red without ACK must keep the trip, all-red with ACK releases it.
  task automatic recover(input string tag);
    set_lamps(R, R);
    ACK = 1'b0;
    step(1);
    n_cmp++;
    if (FAULT !== 1'b1) begin n_bad++; $display("FAIL %s_hold_noack: FAULT=%b want 1", tag, FAULT); end
    ACK = 1'b1;
    step(1);
    n_cmp++;
    if ({FAULT, FCODE, FLASH, ARMED} !== 6'b0) begin
      n_bad++;
      $display("FAIL %s_release: FAULT=%b FCODE=%0d FLASH=%b ARMED=%b want all 0", tag, FAULT, FCODE, FLASH, ARMED);
    end
    ACK = 1'b0;
    step(1);
    n_cmp++;
    if (ARMED !== 1'b1) begin n_bad++; $display("FAIL %s_rearm: ARMED=%b want 1", tag, ARMED); end
  endtask

  task automatic test_reset();
    CLR = 1'b0; TEST = 1'b0; ACK = 1'b0;
    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = 6'bxxxxxx;
    step(3);
    n_cmp++;
    if (FAULT !== 1'b0) begin n_bad++; $display("FAIL reset_fault: FAULT=%b want 0", FAULT); end
    n_cmp++;
    if (FCODE !== 3'd0) begin n_bad++; $display("FAIL reset_fcode: FCODE=%0d want 0", FCODE); end
    n_cmp++;
    if (FLASH !== 1'b0) begin n_bad++; $display("FAIL reset_flash: FLASH=%b want 0", FLASH); end
    n_cmp++;
    if (ARMED !== 1'b0) begin n_bad++; $display("FAIL reset_armed: ARMED=%b want 0", ARMED); end
    CLR = 1'b1;
    set_lamps(R, R);
    step(1);
    n_cmp++;
    if (ARMED !== 1'b0) begin n_bad++; $display("FAIL init_not_yet_armed: ARMED=%b want 0", ARMED); end
    step(1);
    n_cmp++;
    if (ARMED !== 1'b1) begin n_bad++; $display("FAIL init_armed: ARMED=%b want 1", ARMED); end
  endtask

  task automatic test_legal_cycle();
    int bad_cycles;
    bad_cycles = 0;
    TEST = 1'b0;
    for (int it = 0; it < 4; it++) begin
      for (int seg = 0; seg < 4; seg++) begin
        case (seg)
          0: set_lamps(G, R);
          1: set_lamps(Y, R);
          2: set_lamps(R, G);
          default: set_lamps(R, Y);
        endcase
        for (int c = 0; c < ((seg % 2 == 0) ? 8 : 3); c++) begin
          step(1);
          if (FAULT !== 1'b0) bad_cycles++;
        end
      end
    end
    set_lamps(R, R);
    step(3);
    if (FAULT !== 1'b0) bad_cycles++;
    n_cmp++;
    if (bad_cycles !== 0) begin n_bad++; $display("FAIL legal_no_fault: faulted cycles=%0d want 0", bad_cycles); end
    n_cmp++;
    if (ARMED !== 1'b1) begin n_bad++; $display("FAIL legal_armed: ARMED=%b want 1", ARMED); end
  endtask

  task automatic test_conflict();
    set_lamps(G, G);
    step(1);
    n_cmp++;
    if (FAULT !== 1'b0) begin n_bad++; $display("FAIL conflict_early: FAULT=%b want 0", FAULT); end
    step(1);
    n_cmp++;
    if ({FAULT, FCODE, FLASH, ARMED} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL conflict_trip: FAULT=%b FCODE=%0d FLASH=%b ARMED=%b want 1/2/1/0", FAULT, FCODE, FLASH, ARMED);
    end
    recover("conflict");
  endtask

  task automatic test_seq_ack();
    set_lamps(G, R);
    step(2);
    set_lamps(R, R);
    step(2);
    n_cmp++;
    if ({FAULT, FCODE} !== {1'b1, 3'd3}) begin
      n_bad++; $display("FAIL seq_trip: FAULT=%b FCODE=%0d want 1/3", FAULT, FCODE);
    end
    // ACK with a non-red picture is ignored; a new conflict must not overwrite the code.
    set_lamps(G, G);
    step(1);
    ACK = 1'b1;
    step(3);
    n_cmp++;
    if ({FAULT, FCODE, FLASH} !== {1'b1, 3'd3, 1'b1}) begin
      n_bad++; $display("FAIL seq_ack_ignored: FAULT=%b FCODE=%0d FLASH=%b want 1/3/1", FAULT, FCODE, FLASH);
    end
    ACK = 1'b0;
    recover("seq");
  endtask

  task automatic test_short_ylw();
    set_lamps(G, R);
    step(2);
    set_lamps(Y, R);
    step(2);
    set_lamps(R, R);
    step(1);
    n_cmp++;
    if (FAULT !== 1'b0) begin n_bad++; $display("FAIL short_early: FAULT=%b want 0", FAULT); end
    step(1);
    n_cmp++;
    if ({FAULT, FCODE} !== {1'b1, 3'd4}) begin
      n_bad++; $display("FAIL short_trip: FAULT=%b FCODE=%0d want 1/4", FAULT, FCODE);
    end
    recover("short");
    set_lamps(G, R);
    step(2);
    set_lamps(Y, R);
    step(3);
    set_lamps(R, R);
    step(4);
    n_cmp++;
    if ({FAULT, ARMED} !== 2'b01) begin
      n_bad++; $display("FAIL ylw_exact_ok: FAULT=%b ARMED=%b want 0/1", FAULT, ARMED);
    end
  endtask

  task automatic test_stuck();
    int k;
    TEST = 1'b0;
    set_lamps(R, R);
    step(50);
    n_cmp++;
    if (FAULT !== 1'b0) begin n_bad++; $display("FAIL stuck_early: FAULT=%b want 0", FAULT); end
    k = 0;
    while (FAULT !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    n_cmp++;
    if ({FAULT, FCODE} !== {1'b1, 3'd5}) begin
      n_bad++; $display("FAIL stuck_trip: FAULT=%b FCODE=%0d want 1/5", FAULT, FCODE);
    end
    recover("stuck");
    TEST = 1'b1;
    step(100);
    n_cmp++;
    if ({FAULT, ARMED} !== 2'b01) begin
      n_bad++; $display("FAIL stuck_test_mode: FAULT=%b ARMED=%b want 0/1", FAULT, ARMED);
    end
    TEST = 1'b0;
  endtask

  task automatic test_priority_reset();
    set_lamps(GY, G);
    step(2);
    n_cmp++;
    if ({FAULT, FCODE} !== {1'b1, 3'd1}) begin
      n_bad++; $display("FAIL priority_lamp: FAULT=%b FCODE=%0d want 1/1", FAULT, FCODE);
    end
    CLR = 1'b0;
    step(1);
    n_cmp++;
    if ({FAULT, FCODE, FLASH, ARMED} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_in_trip: FAULT=%b FCODE=%0d FLASH=%b ARMED=%b want all 0", FAULT, FCODE, FLASH, ARMED);
    end
    CLR = 1'b1;
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_seq_ack();
    test_short_ylw();
    test_stuck();
    test_priority_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
